// File: rtl/booth_mul_share_arb.sv
// One radix-4 Booth multiplier shared by NREQ requesters through a round-robin arbiter.
// Three pipeline stages: operands, carry-save sum/carry, resolved product.
module booth_mul_share_arb #(
  parameter int DWIDTH = 16,
  parameter int NREQ   = 4,
  parameter int TAGW   = 4,
  parameter int SRCW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_op_a,
  input  logic [NREQ*DWIDTH-1:0] req_op_b,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*DWIDTH-1:0]    rsp_prod,
  output logic [SRCW-1:0]        rsp_src,
  output logic [TAGW-1:0]        rsp_tag,
  output logic [1:0]             inflight
);

  localparam int PW = 2 * DWIDTH;

  function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] dig,
                                                    input logic signed [DWIDTH-1:0] b);
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] pp;
    bx = PW'(b);
    case (dig)
      3'b001, 3'b010: pp = bx;
      3'b011:         pp = bx <<< 1;
      3'b100:         pp = -(bx <<< 1);
      3'b101, 3'b110: pp = -bx;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  logic                     adv;
  logic                     found;
  logic                     accept;
  logic [SRCW-1:0]          gnt_idx;
  logic [SRCW-1:0]          ptr;
  logic signed [DWIDTH-1:0] sel_a;
  logic signed [DWIDTH-1:0] sel_b;
  logic [TAGW-1:0]          sel_tag;

  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [DWIDTH-1:0] op_a_p0, op_b_p0;
  logic [TAGW-1:0]          tag_p0, tag_p1, tag_p2;
  logic [SRCW-1:0]          src_p0, src_p1, src_p2;
  logic signed [PW-1:0]     sum_p1, carry_p1;
  logic signed [PW-1:0]     prod_p2;

  logic signed [PW-1:0]     sum_c, carry_c;
  logic signed [PW-1:0]     acc_s, acc_c, pp_k, nxt_s, nxt_c;
  logic [DWIDTH:0]          a_ext;

  assign adv    = !vld_p2 || rsp_ready;
  assign accept = found && adv;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = SRCW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (SRCW'(i) == gnt_idx) begin
        sel_a   = req_op_a[i*DWIDTH +: DWIDTH];
        sel_b   = req_op_b[i*DWIDTH +: DWIDTH];
        sel_tag = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  // Booth digits folded through a chain of 3:2 compressors; carries stay unresolved.
  always_comb begin
    a_ext = {op_a_p0, 1'b0};
    acc_s = '0;
    acc_c = '0;
    pp_k  = '0;
    nxt_s = '0;
    nxt_c = '0;
    for (int k = 0; k < DWIDTH / 2; k++) begin
      pp_k  = booth_pp(a_ext[2*k +: 3], op_b_p0) <<< (2 * k);
      nxt_s = acc_s ^ acc_c ^ pp_k;
      nxt_c = ((acc_s & acc_c) | (acc_s & pp_k) | (acc_c & pp_k)) <<< 1;
      acc_s = nxt_s;
      acc_c = nxt_c;
    end
    sum_c   = acc_s;
    carry_c = acc_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRCW'(NREQ - 1);
    end else if (accept) begin
      ptr <= gnt_idx;
    end
  end

  // Stage p0: granted operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      op_a_p0 <= '0;
      op_b_p0 <= '0;
      tag_p0  <= '0;
      src_p0  <= '0;
    end else if (adv) begin
      vld_p0  <= accept;
      op_a_p0 <= sel_a;
      op_b_p0 <= sel_b;
      tag_p0  <= sel_tag;
      src_p0  <= gnt_idx;
    end
  end

  // Stage p1: carry-save sum/carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      carry_p1 <= '0;
      tag_p1   <= '0;
      src_p1   <= '0;
    end else if (adv) begin
      vld_p1   <= vld_p0;
      sum_p1   <= sum_c;
      carry_p1 <= carry_c;
      tag_p1   <= tag_p0;
      src_p1   <= src_p0;
    end
  end

  // Stage p2: resolved product, carry-out dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      prod_p2 <= '0;
      tag_p2  <= '0;
      src_p2  <= '0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      prod_p2 <= sum_p1 + carry_p1;
      tag_p2  <= tag_p1;
      src_p2  <= src_p1;
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_prod  = prod_p2;
  assign rsp_src   = src_p2;
  assign rsp_tag   = tag_p2;
  assign inflight  = 2'(vld_p0) + 2'(vld_p1) + 2'(vld_p2);

endmodule

// File: tb/tb_booth_mul_share_arb.sv
// Directed bench for booth_mul_share_arb: vector table plus arbitration/stall/reset sequences.
module tb_booth_mul_share_arb;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_op_a;
  logic [63:0] req_op_b;
  logic [15:0] req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_prod;
  logic [1:0]  rsp_src;
  logic [3:0]  rsp_tag;
  logic [1:0]  inflight;

  booth_mul_share_arb #(.DWIDTH(16), .NREQ(4), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic [1:0]  src;
    logic [3:0]  tag;
  } rsp_t;

  typedef struct {
    int          src;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] prod;
  } vec_t;

  rsp_t exp_q[$];
  rsp_t e;
  vec_t vt[11];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   acc_base, rsp_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t);
    req_valid[i]         = 1'b1;
    req_op_a[i*16 +: 16] = a;
    req_op_b[i*16 +: 16] = b;
    req_tag[i*4 +: 4]    = t;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: inputs are stable from the drive point to the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_prod", rsp_prod, e.prod);
          chk("sb_src", 32'(rsp_src), 32'(e.src));
          chk("sb_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic signed [15:0] sa, sb;
          logic signed [31:0] p;
          sa = req_op_a[i*16 +: 16];
          sb = req_op_b[i*16 +: 16];
          p  = sa * sb;
          exp_q.push_back('{prod: p, src: 2'(i), tag: req_tag[i*4 +: 4]});
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    vt[0]  = '{2, 16'h0003, 16'h0005, 4'hA, 32'h0000000F};
    vt[1]  = '{0, 16'h7FFF, 16'h7FFF, 4'h1, 32'h3FFF0001};
    vt[2]  = '{1, 16'h0000, 16'hFFFF, 4'h2, 32'h00000000};
    vt[3]  = '{3, 16'hFFFF, 16'h0002, 4'h3, 32'hFFFFFFFE};
    vt[4]  = '{0, 16'h8000, 16'h8000, 4'h4, 32'h40000000};
    vt[5]  = '{1, 16'h1234, 16'h0010, 4'h5, 32'h00012340};
    vt[6]  = '{2, 16'h0010, 16'hFFF0, 4'h6, 32'hFFFFFF00};
    vt[7]  = '{3, 16'h5555, 16'h0003, 4'h7, 32'h0000FFFF};
    vt[8]  = '{0, 16'hAAAA, 16'h0003, 4'h8, 32'hFFFEFFFE};
    vt[9]  = '{1, 16'hFFFF, 16'hFFFF, 4'h9, 32'h00000001};
    vt[10] = '{2, 16'h8000, 16'h0001, 4'hB, 32'hFFFF8000};

    rst = 1'b1;
    req_valid = '0;
    req_op_a = '0;
    req_op_b = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_prod", rsp_prod, 0);
    chk("rst_src", 32'(rsp_src), 0);
    chk("rst_tag", 32'(rsp_tag), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    tick;

    // Isolated requests: latency and per-stage occupancy
    foreach (vt[k]) begin
      set_req(vt[k].src, vt[k].a, vt[k].b, vt[k].tag);
      #1;
      chk("tv_ready", 32'(req_ready), 32'(1 << vt[k].src));
      tick;
      req_valid = '0;
      #1;
      chk("tv_infl_s1", 32'(inflight), 1);
      chk("tv_valid_s1", 32'(rsp_valid), 0);
      tick;
      chk("tv_infl_s2", 32'(inflight), 1);
      tick;
      chk("tv_valid_s3", 32'(rsp_valid), 1);
      chk("tv_prod", rsp_prod, vt[k].prod);
      chk("tv_src", 32'(rsp_src), 32'(vt[k].src));
      chk("tv_tag", 32'(rsp_tag), 32'(vt[k].tag));
      chk("tv_infl_s3", 32'(inflight), 1);
      tick;
      chk("tv_infl_done", 32'(inflight), 0);
      chk("tv_valid_done", 32'(rsp_valid), 0);
    end

    // Round-robin with all requesters active
    pulse_rst;
    rsp_base = rsp_cnt;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'h0100, 4'(i));
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      tick;
      if (c >= 2) begin
        chk("rr_valid", 32'(rsp_valid), 1);
        chk("rr_prod", rsp_prod, 32'(((c - 2) % 4 + 1) << 8));
      end
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick;
    chk("rr_count", 32'(rsp_cnt - rsp_base), 8);

    // Backpressure with a full pipe
    acc_base = acc_cnt;
    rsp_base = rsp_cnt;
    set_req(1, 16'h0100, 16'h0020, 4'hC);
    for (int c = 0; c < 4; c++) tick;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_prod", rsp_prod, 32'h00002000);
      chk("bp_tag", 32'(rsp_tag), 32'hC);
      chk("bp_infl", 32'(inflight), 3);
      tick;
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick;
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick;
    chk("bp_accepts", 32'(acc_cnt - acc_base), 7);
    chk("bp_responses", 32'(rsp_cnt - rsp_base), 7);

    // Higher-priority requester appears during a stall
    pulse_rst;
    set_req(1, 16'h0002, 16'h0003, 4'h1);
    #1;
    chk("pr_first", 32'(req_ready), 32'b0010);
    tick;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    set_req(3, 16'h0004, 16'h0005, 4'h3);
    #1;
    chk("pr_stall_r3", 32'(req_ready), 0);
    chk("pr_stall_prod", rsp_prod, 32'd6);
    tick;
    set_req(2, 16'h0006, 16'h0007, 4'h2);
    #1;
    chk("pr_stall_r2", 32'(req_ready), 0);
    tick;
    rsp_ready = 1'b1;
    #1;
    chk("pr_rel_r2", 32'(req_ready), 32'b0100);
    tick;
    req_valid[2] = 1'b0;
    #1;
    chk("pr_then_r3", 32'(req_ready), 32'b1000);
    tick;
    req_valid[3] = 1'b0;
    for (int c = 0; c < 4; c++) tick;

    // Asynchronous reset with a full pipe
    set_req(0, 16'h0009, 16'h0009, 4'h5);
    tick;
    tick;
    tick;
    chk("mr_infl_full", 32'(inflight), 3);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 0);
    chk("mr_infl", 32'(inflight), 0);
    chk("mr_prod", rsp_prod, 0);
    exp_q.delete();
    tick;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h0001, 16'(i + 2), 4'(i));
    #1;
    chk("mr_first", 32'(req_ready), 32'b0001);
    tick;
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick;

    chk("q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
